// File: rtl/sy_ppl_ras_ctrl.sv
// rtl/sy_ppl_ras_ctrl.sv - return-address-stack controller with per-prediction checkpoints (optional SY_RAS_TOP_REPAIR_EN)

package sy_ppl_ras_pkg;
    typedef enum logic [2:0] {
        NORMAL    = 3'd0,
        BRANCH    = 3'd1,
        JUMP      = 3'd2,
        JALR      = 3'd3,
        CALL_JAL  = 3'd4,
        CALL_JALR = 3'd5,
        RET       = 3'd6
    } qdec_type_e;
endpackage

module sy_ppl_ras_ctrl
    import sy_ppl_ras_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int AWTH  = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    input  qdec_type_e       instr_type_i,
    input  logic             instr_is_c_i,
    input  logic [AWTH-1:0]  vaddr_i,
    output logic             ret_valid_o,
    output logic [AWTH-1:0]  ret_addr_o,
    output logic [PTR_W-1:0] ckpt_ptr_o,
    output logic [CNT_W-1:0] ckpt_cnt_o,
    output logic [AWTH-1:0]  ckpt_top_o,
    input  logic             flush_i,
    input  logic [PTR_W-1:0] flush_ptr_i,
    input  logic [CNT_W-1:0] flush_cnt_i,
    input  logic [AWTH-1:0]  flush_top_i,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W-1:0] TP_RST   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [AWTH-1:0]  ras_q [DEPTH];
    logic [AWTH-1:0]  ras_d [DEPTH];
    logic [PTR_W-1:0] tp_q, tp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             is_push;
    logic             is_pop;
    logic [PTR_W-1:0] push_ptr;
    logic [AWTH-1:0]  push_addr;

`ifndef SY_RAS_TOP_REPAIR_EN
    // Without top repair the checkpointed top value has no consumer.
    logic unused_flush_top;
    assign unused_flush_top = ^flush_top_i;
`endif

    assign is_push   = req_valid_i && ((instr_type_i == CALL_JAL) || (instr_type_i == CALL_JALR));
    assign is_pop    = req_valid_i && (instr_type_i == RET);
    assign push_ptr  = tp_q + PTR_W'(1);
    assign push_addr = vaddr_i + (instr_is_c_i ? AWTH'(2) : AWTH'(4));

    // Outputs all describe the stack as it stands before this cycle's request.
    assign ret_addr_o  = ras_q[tp_q];
    assign ret_valid_o = (cnt_q != '0);
    assign ckpt_ptr_o  = tp_q;
    assign ckpt_cnt_o  = cnt_q;
    assign ckpt_top_o  = ras_q[tp_q];
    assign full_o      = (cnt_q == CNT_FULL);
    assign empty_o     = (cnt_q == '0);

    // Next-state: flush wins over any request; a push on a full stack wraps over the oldest entry.
    always_comb begin
        tp_d  = tp_q;
        cnt_d = cnt_q;
        ras_d = ras_q;
        if (flush_i) begin
            tp_d  = flush_ptr_i;
            cnt_d = (flush_cnt_i > CNT_FULL) ? CNT_FULL : flush_cnt_i;
`ifdef SY_RAS_TOP_REPAIR_EN
            ras_d[flush_ptr_i] = flush_top_i;
`endif
        end else if (is_push) begin
            tp_d            = push_ptr;
            ras_d[push_ptr] = push_addr;
            cnt_d           = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + CNT_W'(1);
        end else if (is_pop && (cnt_q != '0)) begin
            tp_d  = tp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State register; reset parks tp on the last entry so the first push lands in entry 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tp_q  <= TP_RST;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                ras_q[i] <= ras_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sy_ppl_ras_ctrl.sv
// tb/tb_sy_ppl_ras_ctrl.sv - self-checking bench for sy_ppl_ras_ctrl

module tb_sy_ppl_ras_ctrl;
    import sy_ppl_ras_pkg::*;

    localparam int DEPTH = 8;
    localparam int AWTH  = 32;
    localparam int PTR_W = 3;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    qdec_type_e       instr_type = NORMAL;
    logic             instr_is_c = 1'b0;
    logic [AWTH-1:0]  vaddr = '0;
    logic             ret_valid;
    logic [AWTH-1:0]  ret_addr;
    logic [PTR_W-1:0] ckpt_ptr;
    logic [CNT_W-1:0] ckpt_cnt;
    logic [AWTH-1:0]  ckpt_top;
    logic             flush = 1'b0;
    logic [PTR_W-1:0] flush_ptr = '0;
    logic [CNT_W-1:0] flush_cnt = '0;
    logic [AWTH-1:0]  flush_top = '0;
    logic             full;
    logic             empty;

    int total = 0;
    int bad   = 0;

    // Reference: a circular array of return addresses with an integer top index and count.
    logic [AWTH-1:0] m_ras [DEPTH];
    int              m_tp;
    int              m_cnt;

    always #5 clk = ~clk;

    sy_ppl_ras_ctrl #(.DEPTH(DEPTH), .AWTH(AWTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .instr_type_i(instr_type), .instr_is_c_i(instr_is_c), .vaddr_i(vaddr),
        .ret_valid_o(ret_valid), .ret_addr_o(ret_addr),
        .ckpt_ptr_o(ckpt_ptr), .ckpt_cnt_o(ckpt_cnt), .ckpt_top_o(ckpt_top),
        .flush_i(flush), .flush_ptr_i(flush_ptr), .flush_cnt_i(flush_cnt), .flush_top_i(flush_top),
        .full_o(full), .empty_o(empty)
    );

    task automatic chk(input string name, input logic [AWTH-1:0] act, input logic [AWTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_tp  = DEPTH - 1;
        m_cnt = 0;
        for (int i = 0; i < DEPTH; i++) m_ras[i] = '0;
    endfunction

    function automatic void model_step();
        if (flush) begin
            m_tp  = int'(flush_ptr);
            m_cnt = (int'(flush_cnt) > DEPTH) ? DEPTH : int'(flush_cnt);
`ifdef SY_RAS_TOP_REPAIR_EN
            m_ras[m_tp] = flush_top;
`endif
        end else if (req_valid && (instr_type == CALL_JAL || instr_type == CALL_JALR)) begin
            m_tp        = (m_tp + 1) % DEPTH;
            m_ras[m_tp] = vaddr + (instr_is_c ? 32'd2 : 32'd4);
            if (m_cnt < DEPTH) m_cnt++;
        end else if (req_valid && instr_type == RET && m_cnt > 0) begin
            m_tp = (m_tp + DEPTH - 1) % DEPTH;
            m_cnt--;
        end
    endfunction

    // Every falling edge: DUT outputs against the reference.
    always @(negedge clk) begin
        assert (int'(flush_cnt) <= DEPTH);
        chk("m_ret_valid", ret_valid, m_cnt != 0);
        chk("m_ret_addr", ret_addr, m_ras[m_tp]);
        chk("m_ckpt_ptr", ckpt_ptr, m_tp);
        chk("m_ckpt_cnt", ckpt_cnt, m_cnt);
        chk("m_ckpt_top", ckpt_top, m_ras[m_tp]);
        chk("m_full", full, m_cnt == DEPTH);
        chk("m_empty", empty, m_cnt == 0);
    end

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid  = 1'b0;
        instr_type = NORMAL;
        instr_is_c = 1'b0;
        vaddr      = '0;
        flush      = 1'b0;
    endtask

    task automatic req(input qdec_type_e t, input logic c, input logic [AWTH-1:0] a);
        req_valid  = 1'b1;
        instr_type = t;
        instr_is_c = c;
        vaddr      = a;
        tick();
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    logic [PTR_W-1:0] sv_ptr;
    logic [CNT_W-1:0] sv_cnt;
    logic [AWTH-1:0]  sv_top;

    initial begin
        model_reset();
        idle();
        tick();
        rst = 1'b0;

        chk("rst_valid", ret_valid, 0);
        chk("rst_addr", ret_addr, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ptr", ckpt_ptr, 7);

        req(CALL_JAL, 1'b0, 32'h1000);
        chk("call_valid", ret_valid, 1);
        chk("call_addr", ret_addr, 32'h1004);
        chk("call_cnt", ckpt_cnt, 1);
        chk("call_empty", empty, 0);
        chk("call_ptr", ckpt_ptr, 0);

        req(CALL_JALR, 1'b1, 32'h2000);
        chk("callc_addr", ret_addr, 32'h2002);
        req_valid = 1'b1; instr_type = RET;
        chk("ret_during", ret_addr, 32'h2002);
        tick(); idle();
        chk("ret_after_cnt", ckpt_cnt, 1);
        chk("ret_after_top", ret_addr, 32'h1004);
        req(RET, 1'b0, 32'h0);
        chk("ret_empty", empty, 1);

        req(RET, 1'b0, 32'h0);
        chk("ret0_valid", ret_valid, 0);
        chk("ret0_ptr", ckpt_ptr, 7);
        chk("ret0_cnt", ckpt_cnt, 0);

        // Non-call/return types and deasserted valid leave state alone.
        req(CALL_JAL, 1'b0, 32'h0C00);
        req(NORMAL, 1'b0, 32'h40);
        req(BRANCH, 1'b0, 32'h44);
        req(JUMP, 1'b0, 32'h48);
        req(JALR, 1'b1, 32'h4C);
        req_valid = 1'b0; instr_type = CALL_JAL; vaddr = 32'h9000;
        tick(); idle();
        chk("noop_addr", ret_addr, 32'h0C04);
        chk("noop_cnt", ckpt_cnt, 1);
        req(RET, 1'b0, 32'h0);

        for (int i = 1; i <= 10; i++) req(CALL_JAL, 1'b0, 32'h100 * i);
        chk("ovf_full", full, 1);
        chk("ovf_cnt", ckpt_cnt, 8);
        chk("ovf_top", ret_addr, 32'hA04);
        for (int k = 0; k < 8; k++) begin
            req_valid = 1'b1; instr_type = RET;
            chk("ovf_pop", ret_addr, 32'h100 * (10 - k) + 32'h4);
            tick(); idle();
        end
        chk("ovf_empty", empty, 1);

        // Wrong-path rewind.
        do_reset();
        req(CALL_JAL, 1'b0, 32'h1000);
        req(CALL_JAL, 1'b0, 32'h3000);
        sv_ptr = ckpt_ptr; sv_cnt = ckpt_cnt; sv_top = ckpt_top;
        chk("ck_top", sv_top, 32'h3004);
        req(RET, 1'b0, 32'h0);
        req(CALL_JAL, 1'b0, 32'h5000);
        flush = 1'b1; flush_ptr = sv_ptr; flush_cnt = sv_cnt; flush_top = sv_top;
        tick(); idle();
        chk("fl_ptr", ckpt_ptr, 1);
        chk("fl_cnt", ckpt_cnt, 2);
`ifdef SY_RAS_TOP_REPAIR_EN
        chk("fl_top", ret_addr, 32'h3004);
`else
        chk("fl_top", ret_addr, 32'h5004);
`endif

        // Flush and call together: the call is dropped.
        flush = 1'b1; flush_ptr = 3'd0; flush_cnt = 4'd1; flush_top = 32'h1004;
        req_valid = 1'b1; instr_type = CALL_JAL; vaddr = 32'h7000;
        tick(); idle();
        chk("flc_ptr", ckpt_ptr, 0);
        chk("flc_cnt", ckpt_cnt, 1);
        chk("flc_top", ret_addr, 32'h1004);

        // Flush to a full count.
        flush = 1'b1; flush_ptr = 3'd3; flush_cnt = 4'd8; flush_top = 32'h0;
        tick(); idle();
        chk("flf_full", full, 1);
        chk("flf_ptr", ckpt_ptr, 3);

        // Asynchronous reset mid-cycle with flush and request both active.
        req(CALL_JAL, 1'b0, 32'h8000);
        flush = 1'b1; flush_ptr = 3'd2; flush_cnt = 4'd5;
        req_valid = 1'b1; instr_type = CALL_JAL; vaddr = 32'h6000;
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", ret_valid, 0);
        chk("arst_addr", ret_addr, 0);
        chk("arst_ptr", ckpt_ptr, 7);
        chk("arst_empty", empty, 1);
        tick();
        rst = 1'b0;
        idle();
        tick();
        chk("arst_post_cnt", ckpt_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1);
    end

endmodule
